// File: rtl/regfile_mp.sv
// Parametrised register file with NRD registered read ports and one byte-masked write port.
// Reads are write-first with per-byte bypass. Define ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD-1:0]          rd_en,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_valid,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W/8-1:0]     wr_be,
  input  logic [DATA_W-1:0]       wr_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_next [NRD];
  logic              wr_eff;

  // Writes to entry 0 are dropped when it is hardwired, which also keeps
  // the bypass path from ever exposing a nonzero value for address 0.
  always_comb begin
`ifdef ZERO_REG_EN
    wr_eff = wr_en && (wr_addr != '0);
`else
    wr_eff = wr_en;
`endif
  end

  always_comb begin
    wr_merged = mem[wr_addr];
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_next[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
      if (wr_eff && (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr)) rd_next[p] = wr_merged;
    end
  end

  // rd_valid[p] is high for exactly the cycle after an edge that sampled
  // rd_en[p]=1; rd_data[p] holds its last value whenever rd_valid[p] is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= DATA_W'(a + 1);
      end
`ifdef ZERO_REG_EN
      mem[0] <= '0;
`endif
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      if (wr_eff) mem[wr_addr] <= wr_merged;
      for (int p = 0; p < NRD; p++) begin
        rd_valid[p] <= rd_en[p];
        if (rd_en[p]) rd_data[p*DATA_W +: DATA_W] <= rd_next[p];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (NRD=2, 32x32): directed cases plus random traffic
// scored against a behavioural memory model through per-port expected queues.
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_valid;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [NB-1:0]         wr_be;
  logic [DATA_W-1:0]     wr_data;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  logic [DATA_W-1:0] last_exp [NRD];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void reset_model();
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = DATA_W'(a + 1);
`ifdef ZERO_REG_EN
    ref_mem[0] = '0;
`endif
    for (int p = 0; p < NRD; p++) last_exp[p] = '0;
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
`ifdef ZERO_REG_EN
    if (a == '0) return '0;
`endif
    return ref_mem[a];
  endfunction

  // driver: present one cycle of stimulus, update the model write-first,
  // queue expected read results, then advance to the next falling edge
  task automatic issue(input logic [NRD-1:0] en, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic we, input logic [ADDR_W-1:0] wa, input logic [NB-1:0] be,
                       input logic [DATA_W-1:0] wd, input bit use_lit,
                       input logic [DATA_W-1:0] l0, input logic [DATA_W-1:0] l1);
    bit drop;
    rd_en   = en;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_be   = be;
    wr_data = wd;
    drop = 1'b0;
`ifdef ZERO_REG_EN
    drop = (wa == '0);
`endif
    if (we && !drop) begin
      for (int b = 0; b < NB; b++) if (be[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
    end
    if (en[0]) exp_q0.push_back(use_lit ? l0 : model_read(a0));
    if (en[1]) exp_q1.push_back(use_lit ? l1 : model_read(a1));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    issue('0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  // monitor: pop and compare whenever a port presents valid data,
  // otherwise confirm the port holds its last value
  always @(negedge clk) begin
    logic [DATA_W-1:0] act;
    logic [DATA_W-1:0] e;
    for (int p = 0; p < NRD; p++) begin
      act = rd_data[p*DATA_W +: DATA_W];
      if (rd_valid[p] === 1'b1) begin
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid port %0d: got valid=1 data %h expected valid=0", p, act);
        end else begin
          e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("read_port%0d", p), act, e);
          last_exp[p] = e;
        end
      end else begin
        check($sformatf("hold_port%0d", p), act, last_exp[p]);
      end
    end
  end

  initial begin
    logic [NRD-1:0]    en;
    logic [ADDR_W-1:0] a0, a1, wa;
    logic              we;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wd;

    rst = 1'b0;
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    reset_model();
    repeat (2) @(negedge clk);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data_p0", rd_data[31:0], 32'd0);
    check("reset_rd_data_p1", rd_data[63:32], 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // reset contents: addr 3 -> 4, addr 0 -> 1 (0 when hardwired)
    issue(2'b01, 5'd3, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'd4, 32'd0);
`ifdef ZERO_REG_EN
    issue(2'b11, 5'd0, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'd0, 32'd0);
`else
    issue(2'b11, 5'd0, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'd1, 32'd1);
`endif

    // full-word write then read
    issue(2'b00, '0, '0, 1'b1, 5'd7, 4'hF, 32'hDEADBEEF, 1'b0, '0, '0);
    issue(2'b01, 5'd7, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'hDEADBEEF, 32'd0);

    // byte-merged bypass on port 1
    issue(2'b00, '0, '0, 1'b1, 5'd9, 4'hF, 32'h11223344, 1'b0, '0, '0);
    issue(2'b10, 5'd0, 5'd9, 1'b1, 5'd9, 4'b0101, 32'hAABBCCDD, 1'b1, 32'd0, 32'h11BB33DD);
    issue(2'b01, 5'd9, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'h11BB33DD, 32'd0);

    // entry 0 write with same-edge read on both ports
`ifdef ZERO_REG_EN
    issue(2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 4'hF, 32'h55, 1'b1, 32'd0, 32'd0);
    issue(2'b11, 5'd0, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'd0, 32'd0);
`else
    issue(2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 4'h1, 32'h55, 1'b1, 32'h55, 32'h55);
    issue(2'b11, 5'd0, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'h55, 32'h55);
`endif
    // byte-enable zero write is a no-op
    issue(2'b00, '0, '0, 1'b1, 5'd7, 4'h0, 32'h12345678, 1'b0, '0, '0);
    issue(2'b01, 5'd7, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'hDEADBEEF, 32'd0);

    // hold: read addr 5, then three idle cycles
    issue(2'b01, 5'd5, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'd6, 32'd0);
    repeat (3) idle();

    // async reset in the middle of a write cycle
    rd_en = '0; wr_en = 1'b1; wr_addr = 5'd2; wr_be = 4'hF; wr_data = 32'hCAFEF00D;
    #2;
    rst = 1'b0;
    reset_model();
    #1;
    check("async_rd_data", rd_data[31:0], 32'd0);
    check("async_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    issue(2'b01, 5'd2, 5'd0, 1'b0, '0, '0, '0, 1'b1, 32'd3, 32'd0);

    // random traffic against the model
    repeat (400) begin
      en = NRD'($urandom_range(0, 3));
      wa = ADDR_W'($urandom_range(0, DEPTH - 1));
      a0 = ($urandom_range(0, 2) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : (($urandom_range(0, 2) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1)));
      we = 1'($urandom_range(0, 1));
      be = NB'($urandom_range(0, 15));
      wd = $urandom;
      issue(en, a0, a1, we, wa, be, wd, 1'b0, '0, '0);
    end

    // sweep every address on both ports
    for (int a = 0; a < DEPTH; a++) begin
      issue(2'b11, ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), 1'b0, '0, '0, '0, 1'b0, '0, '0);
    end

    repeat (2) idle();
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 32'(exp_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
